// File: rtl/morse_input_sequencer_pkg.sv
// Shared types and constants for the Morse input sequencer: FSM states, symbol codes,
// separator word, button bit positions and parameter defaults.
package morse_input_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_REQ   = 2'd2,
    ST_SENT  = 2'd3
  } morse_state_t;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [9:0] SEP_WORD = 10'h3FF;

  localparam int DOT_CYC_DEF  = 4;
  localparam int DASH_CYC_DEF = 12;
  localparam int MAX_SYM_DEF  = 5;
  localparam int SLOTS_DEF    = 3;

  // Bit positions in the packed button vector.
  localparam int BTN_DOT   = 0;
  localparam int BTN_DASH  = 1;
  localparam int BTN_SPACE = 2;
  localparam int BTN_END   = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_CLEAR = 5;

  function automatic logic [9:0] push_sym(input logic [9:0] seq, input logic [1:0] code);
    return {seq[7:0], code};
  endfunction

endpackage

// File: rtl/morse_input_sequencer_buzzer_timer.sv
// Buzzer timer: a start pulse loads the dot or dash length and lights the matching buzzer;
// a restart always switches off the other buzzer so both are never high together.
module morse_buzzer_timer
  import morse_input_sequencer_pkg::*;
#(
  parameter int DOT_CYC  = DOT_CYC_DEF,
  parameter int DASH_CYC = DASH_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_dash,
  output logic dot_buzzer,
  output logic dash_buzzer
);

  localparam int LONGEST = (DASH_CYC > DOT_CYC) ? DASH_CYC : DOT_CYC;
  localparam int CW      = $clog2(LONGEST + 1);
  localparam logic [CW-1:0] DOT_LOAD  = CW'(DOT_CYC - 1);
  localparam logic [CW-1:0] DASH_LOAD = CW'(DASH_CYC - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [CW-1:0] remain;

  // The start clock itself is the first buzzer clock, hence the length-1 load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain      <= '0;
      dot_buzzer  <= 1'b0;
      dash_buzzer <= 1'b0;
    end else if (start) begin
      remain      <= is_dash ? DASH_LOAD : DOT_LOAD;
      dot_buzzer  <= !is_dash;
      dash_buzzer <= is_dash;
    end else if (remain != '0) begin
      remain <= remain - ONE;
    end else begin
      dot_buzzer  <= 1'b0;
      dash_buzzer <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_input_sequencer.sv
// Morse input sequencer: edge-detects six buttons, builds a symbol sequence, stores finished
// sequences into slots and hands the slot bank to a translator via a request/ack handshake.
module morse_input_sequencer
  import morse_input_sequencer_pkg::*;
#(
  parameter int DOT_CYC  = DOT_CYC_DEF,
  parameter int DASH_CYC = DASH_CYC_DEF,
  parameter int MAX_SYM  = MAX_SYM_DEF,
  parameter int SLOTS    = SLOTS_DEF
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Dot,
  input  logic               Dash,
  input  logic               Space,
  input  logic               EndSeq,
  input  logic               Enter,
  input  logic               Clear,
  input  logic               trans_ack,
  output logic               dot_buzzer,
  output logic               dash_buzzer,
  output logic [9:0]         cur_seq,
  output logic [SLOTS*10-1:0] store_seqs,
  output logic [1:0]         slot_cnt,
  output logic               store_wr,
  output logic               trans_req,
  output logic               sent,
  output logic               overflow,
  output morse_state_t       fsm_state
);

  localparam int SCW = $clog2(MAX_SYM + 1);
  localparam logic [SCW-1:0] MAX_SYM_L = SCW'(MAX_SYM);
  localparam logic [SCW-1:0] SYM_ONE   = SCW'(1);
  localparam logic [1:0]     SLOTS_L   = 2'(SLOTS);

  morse_state_t state, state_n;

  logic [5:0]     btn_raw, btn_smp, btn_prev, btn_edge;
  logic [9:0]     cur_seq_n;
  logic [SCW-1:0] sym_cnt, sym_cnt_n;
  logic [9:0]     slots [SLOTS];
  logic [9:0]     slots_n [SLOTS];
  logic [1:0]     wc;
  logic           overflow_n, store_wr_n, trans_req_n;
  logic           sep_pend, sep_pend_n;
  logic           buzz_start, buzz_dash;

  assign btn_raw  = {Clear, Enter, EndSeq, Space, Dash, Dot};
  assign btn_edge = btn_smp & ~btn_prev;

  assign sent      = (state == ST_SENT);
  assign fsm_state = state;

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign store_seqs[g*10 +: 10] = slots[g];
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      btn_smp   <= '0;
      btn_prev  <= '0;
      cur_seq   <= '0;
      sym_cnt   <= '0;
      slot_cnt  <= '0;
      store_wr  <= 1'b0;
      trans_req <= 1'b0;
      overflow  <= 1'b0;
      sep_pend  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
    end else begin
      state     <= state_n;
      btn_smp   <= btn_raw;
      btn_prev  <= btn_smp;
      cur_seq   <= cur_seq_n;
      sym_cnt   <= sym_cnt_n;
      slot_cnt  <= wc;
      store_wr  <= store_wr_n;
      trans_req <= trans_req_n;
      overflow  <= overflow_n;
      sep_pend  <= sep_pend_n;
      for (int i = 0; i < SLOTS; i++) slots[i] <= slots_n[i];
    end
  end

  // Handshake: trans_req is a level held from the clock after Enter takes effect until
  // trans_ack is seen as a one-cycle pulse while trans_req is high; acks at any other time
  // are ignored. wc is the running slot count, so a pending separator and a same-clock
  // commit land in consecutive slots.
  always_comb begin
    state_n    = state;
    cur_seq_n  = cur_seq;
    sym_cnt_n  = sym_cnt;
    slots_n    = slots;
    wc         = slot_cnt;
    overflow_n = overflow;
    sep_pend_n = 1'b0;
    store_wr_n = 1'b0;
    buzz_start = 1'b0;
    buzz_dash  = 1'b0;

    unique case (state)
      ST_IDLE, ST_BUILD: begin
        if (sep_pend && wc < SLOTS_L) begin
          slots_n[wc] = SEP_WORD;
          wc          = wc + 2'd1;
          store_wr_n  = 1'b1;
        end

        if (btn_edge[BTN_CLEAR]) begin
          cur_seq_n  = '0;
          sym_cnt_n  = '0;
          overflow_n = 1'b0;
          state_n    = ST_IDLE;
        end else if (btn_edge[BTN_ENTER]) begin
          if (wc != 2'd0 || sym_cnt != '0) begin
            if (sym_cnt != '0) begin
              if (wc < SLOTS_L) begin
                slots_n[wc] = cur_seq;
                wc          = wc + 2'd1;
                store_wr_n  = 1'b1;
              end else begin
                overflow_n = 1'b1;
              end
              cur_seq_n = '0;
              sym_cnt_n = '0;
            end
            state_n = ST_REQ;
          end
        end else if (btn_edge[BTN_END]) begin
          if (sym_cnt != '0) begin
            if (wc < SLOTS_L) begin
              slots_n[wc] = cur_seq;
              wc          = wc + 2'd1;
              store_wr_n  = 1'b1;
            end else begin
              overflow_n = 1'b1;
            end
            cur_seq_n = '0;
            sym_cnt_n = '0;
            state_n   = ST_IDLE;
          end
        end else if (btn_edge[BTN_SPACE]) begin
          if (wc < SLOTS_L) begin
            if (sym_cnt != '0) begin
              slots_n[wc] = cur_seq;
              wc          = wc + 2'd1;
              store_wr_n  = 1'b1;
              cur_seq_n   = '0;
              sym_cnt_n   = '0;
              state_n     = ST_IDLE;
              sep_pend_n  = (wc < SLOTS_L);
            end else begin
              slots_n[wc] = SEP_WORD;
              wc          = wc + 2'd1;
              store_wr_n  = 1'b1;
            end
          end
        end else if (btn_edge[BTN_DASH] || btn_edge[BTN_DOT]) begin
          if (sym_cnt == MAX_SYM_L) begin
            overflow_n = 1'b1;
          end else begin
            cur_seq_n  = push_sym(cur_seq, btn_edge[BTN_DASH] ? SYM_DASH : SYM_DOT);
            sym_cnt_n  = sym_cnt + SYM_ONE;
            buzz_start = 1'b1;
            buzz_dash  = btn_edge[BTN_DASH];
            state_n    = ST_BUILD;
          end
        end
      end

      ST_REQ: begin
        if (trans_req && trans_ack) state_n = ST_SENT;
      end

      ST_SENT: begin
        for (int i = 0; i < SLOTS; i++) slots_n[i] = '0;
        wc         = 2'd0;
        cur_seq_n  = '0;
        sym_cnt_n  = '0;
        overflow_n = 1'b0;
        state_n    = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    trans_req_n = (state == ST_REQ) && (state_n == ST_REQ);
  end

  morse_buzzer_timer #(
    .DOT_CYC  (DOT_CYC),
    .DASH_CYC (DASH_CYC)
  ) u_buzzer (
    .clk         (clk),
    .rst_n       (Reset_n),
    .start       (buzz_start),
    .is_dash     (buzz_dash),
    .dot_buzzer  (dot_buzzer),
    .dash_buzzer (dash_buzzer)
  );

endmodule

// File: tb/tb_morse_input_sequencer.sv
// Bench for morse_input_sequencer: directed scenarios plus randomized button traffic
// compared against a sequence-level model (symbol list, slot list, overflow, request flag).
module tb_morse_input_sequencer;
  import morse_input_sequencer_pkg::*;

  localparam int DOT_CYC  = 4;
  localparam int DASH_CYC = 12;
  localparam int MAX_SYM  = 5;
  localparam int SLOTS    = 3;

  localparam logic [5:0] P_DOT   = 6'b000001;
  localparam logic [5:0] P_DASH  = 6'b000010;
  localparam logic [5:0] P_SPACE = 6'b000100;
  localparam logic [5:0] P_END   = 6'b001000;
  localparam logic [5:0] P_ENTER = 6'b010000;
  localparam logic [5:0] P_CLEAR = 6'b100000;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Dot = 1'b0, Dash = 1'b0, Space = 1'b0, EndSeq = 1'b0, Enter = 1'b0, Clear = 1'b0;
  logic trans_ack = 1'b0;
  logic dot_buzzer, dash_buzzer, store_wr, trans_req, sent, overflow;
  logic [9:0]  cur_seq;
  logic [29:0] store_seqs;
  logic [1:0]  slot_cnt;
  morse_state_t fsm_state;

  always #5 clk = ~clk;

  morse_input_sequencer #(
    .DOT_CYC(DOT_CYC), .DASH_CYC(DASH_CYC), .MAX_SYM(MAX_SYM), .SLOTS(SLOTS)
  ) dut (
    .clk(clk), .Reset_n(Reset_n),
    .Dot(Dot), .Dash(Dash), .Space(Space), .EndSeq(EndSeq), .Enter(Enter), .Clear(Clear),
    .trans_ack(trans_ack),
    .dot_buzzer(dot_buzzer), .dash_buzzer(dash_buzzer),
    .cur_seq(cur_seq), .store_seqs(store_seqs), .slot_cnt(slot_cnt),
    .store_wr(store_wr), .trans_req(trans_req), .sent(sent), .overflow(overflow),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int sent_cnt = 0;

  // Scoreboard of slot writes in expected order, plus the sequence-level model.
  logic [9:0] exp_q[$];
  int         m_syms[$];
  logic [9:0] m_slots[$];
  bit         m_ovf;
  bit         m_req;

  int         mon_idx;
  logic [9:0] mon_got, mon_exp;

  always @(negedge clk) begin
    if (Reset_n) begin
      checks++;
      if (dot_buzzer && dash_buzzer) begin
        errors++;
        $display("FAIL buzz_exclusive: dot=%b dash=%b, required not both high", dot_buzzer, dash_buzzer);
      end
      if (sent) sent_cnt++;
      if (store_wr) begin
        wr_cnt++;
        checks++;
        mon_idx = int'(slot_cnt) - 1;
        if (mon_idx < 0 || exp_q.size() == 0) begin
          errors++;
          $display("FAIL store_wr_unexpected: slot_cnt=%0d queued=%0d", slot_cnt, exp_q.size());
        end else begin
          mon_got = store_seqs[mon_idx*10 +: 10];
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL store_word: slot%0d got %h required %h", mon_idx, mon_got, mon_exp);
          end
        end
      end
    end
  end

  function automatic logic [9:0] m_cur();
    int v = 0;
    foreach (m_syms[i]) v = (v * 4 + m_syms[i]) % 1024;
    return 10'(v);
  endfunction

  function automatic logic [29:0] m_pack();
    logic [29:0] p = '0;
    foreach (m_slots[i]) p[i*10 +: 10] = m_slots[i];
    return p;
  endfunction

  function automatic void m_commit(input logic [9:0] w);
    m_slots.push_back(w);
    exp_q.push_back(w);
  endfunction

  function automatic void model_press(input logic [5:0] m);
    if (m_req || m == 6'b0) return;
    if (m[5]) begin
      m_syms.delete();
      m_ovf = 1'b0;
    end else if (m[4]) begin
      if (m_slots.size() > 0 || m_syms.size() > 0) begin
        if (m_syms.size() > 0) begin
          if (m_slots.size() < SLOTS) m_commit(m_cur());
          else m_ovf = 1'b1;
          m_syms.delete();
        end
        m_req = 1'b1;
      end
    end else if (m[3]) begin
      if (m_syms.size() > 0) begin
        if (m_slots.size() < SLOTS) m_commit(m_cur());
        else m_ovf = 1'b1;
        m_syms.delete();
      end
    end else if (m[2]) begin
      if (m_slots.size() < SLOTS) begin
        if (m_syms.size() > 0) begin
          m_commit(m_cur());
          m_syms.delete();
        end
        if (m_slots.size() < SLOTS) m_commit(SEP_WORD);
      end
    end else begin
      if (m_syms.size() >= MAX_SYM) m_ovf = 1'b1;
      else m_syms.push_back(m[1] ? 2 : 1);
    end
  endfunction

  task automatic press(input logic [5:0] m, input int hold);
    model_press(m);
    {Clear, Enter, EndSeq, Space, Dash, Dot} = m;
    repeat (hold) @(negedge clk);
    {Clear, Enter, EndSeq, Space, Dash, Dot} = 6'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ack();
    trans_ack = 1'b1;
    @(negedge clk);
    trans_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes: %0d expected slot writes never seen, required 0", exp_q.size());
    end
    Reset_n = 1'b0;
    {Clear, Enter, EndSeq, Space, Dash, Dot} = 6'b0;
    trans_ack = 1'b0;
    exp_q.delete();
    m_syms.delete();
    m_slots.delete();
    m_ovf = 1'b0;
    m_req = 1'b0;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cur_seq, store_seqs, slot_cnt} !== 42'h0) begin
      errors++;
      $display("FAIL reset_data: cur_seq=%h store_seqs=%h slot_cnt=%0d, required all 0", cur_seq, store_seqs, slot_cnt);
    end
    checks++;
    if ({dot_buzzer, dash_buzzer, store_wr, trans_req, sent, overflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: dot=%b dash=%b wr=%b req=%b sent=%b ovf=%b, required all 0",
               dot_buzzer, dash_buzzer, store_wr, trans_req, sent, overflow);
    end
  endtask

  task automatic test_latency();
    int hi;
    do_reset();
    model_press(P_DOT);
    Dot = 1'b1;
    @(negedge clk);
    checks++;
    if (cur_seq !== 10'h000 || dot_buzzer !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: cur_seq=%h dot=%b, required 000 and 0", cur_seq, dot_buzzer);
    end
    @(negedge clk);
    Dot = 1'b0;
    checks++;
    if (cur_seq !== m_cur() || dot_buzzer !== 1'b1) begin
      errors++;
      $display("FAIL latency_effect: cur_seq=%h dot=%b, required %h and 1", cur_seq, dot_buzzer, m_cur());
    end
    hi = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hi += int'(dot_buzzer);
    end
    checks++;
    if (hi != DOT_CYC) begin
      errors++;
      $display("FAIL dot_length: high %0d clocks, required %0d", hi, DOT_CYC);
    end
  endtask

  task automatic test_simultaneous();
    int dash_hi = 0;
    int dot_hi = 0;
    do_reset();
    model_press(P_DOT | P_DASH);
    Dot = 1'b1;
    Dash = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        Dot = 1'b0;
        Dash = 1'b0;
      end
      dash_hi += int'(dash_buzzer);
      dot_hi  += int'(dot_buzzer);
    end
    checks++;
    if (cur_seq !== 10'h002 || cur_seq !== m_cur()) begin
      errors++;
      $display("FAIL simul_seq: cur_seq=%h, required 002", cur_seq);
    end
    checks++;
    if (dash_hi != DASH_CYC || dot_hi != 0) begin
      errors++;
      $display("FAIL simul_buzz: dash high %0d dot high %0d, required %0d and 0", dash_hi, dot_hi, DASH_CYC);
    end
  endtask

  task automatic test_scenario();
    int n;
    int s0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) press((k == 1) ? P_DASH : P_DOT, 10);
      press(P_END, 10);
    end
    checks++;
    if (store_seqs !== {10'h015, 10'h02A, 10'h015} || store_seqs !== m_pack() || slot_cnt !== 2'd3) begin
      errors++;
      $display("FAIL scen_slots: store_seqs=%h slot_cnt=%0d, required %h and 3",
               store_seqs, slot_cnt, {10'h015, 10'h02A, 10'h015});
    end
    model_press(P_ENTER);
    Enter = 1'b1;
    n = 0;
    while (trans_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      Enter = 1'b0;
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL trans_req_latency: rose after %0d clocks, required 3", n);
    end
    repeat (5) @(negedge clk);
    s0 = sent_cnt;
    pulse_ack();
    m_slots.delete();
    m_ovf = 1'b0;
    m_req = 1'b0;
    checks++;
    if (sent_cnt - s0 != 1) begin
      errors++;
      $display("FAIL scen_sent: %0d sent pulses, required 1", sent_cnt - s0);
    end
    checks++;
    if (slot_cnt !== 2'd0 || store_seqs !== 30'h0 || trans_req !== 1'b0) begin
      errors++;
      $display("FAIL scen_cleared: slot_cnt=%0d store_seqs=%h req=%b, required 0", slot_cnt, store_seqs, trans_req);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) press(P_DOT, 2);
    checks++;
    if (cur_seq !== 10'h155 || cur_seq !== m_cur() || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sym_overflow: cur_seq=%h ovf=%b, required 155 and 1", cur_seq, overflow);
    end
    press(P_CLEAR, 2);
    checks++;
    if (cur_seq !== 10'h000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear: cur_seq=%h ovf=%b, required 000 and 0", cur_seq, overflow);
    end
  endtask

  task automatic test_space();
    int w0;
    do_reset();
    w0 = wr_cnt;
    press(P_DOT, 1);
    press(P_DASH, 1);
    press(P_SPACE, 2);
    checks++;
    if (wr_cnt - w0 != 2 || slot_cnt !== 2'd2 || cur_seq !== 10'h000) begin
      errors++;
      $display("FAIL space_commit: writes=%0d slot_cnt=%0d cur_seq=%h, required 2, 2, 000", wr_cnt - w0, slot_cnt, cur_seq);
    end
    press(P_SPACE, 1);
    checks++;
    if (store_seqs !== {10'h3FF, 10'h3FF, 10'h006} || store_seqs !== m_pack()) begin
      errors++;
      $display("FAIL space_sep: store_seqs=%h, required %h", store_seqs, {10'h3FF, 10'h3FF, 10'h006});
    end
  endtask

  task automatic test_full_slots();
    int w0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      int n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) press(($urandom_range(0, 1) == 1) ? P_DASH : P_DOT, $urandom_range(1, 3));
      press(P_END, 2);
    end
    w0 = wr_cnt;
    press(P_DASH, 2);
    press(P_END, 2);
    press(P_SPACE, 2);
    checks++;
    if (wr_cnt != w0 || overflow !== 1'b1 || slot_cnt !== 2'd3) begin
      errors++;
      $display("FAIL full_drop: writes=%0d ovf=%b slot_cnt=%0d, required 0, 1, 3", wr_cnt - w0, overflow, slot_cnt);
    end
    checks++;
    if (store_seqs !== m_pack() || cur_seq !== 10'h000) begin
      errors++;
      $display("FAIL full_keep: store_seqs=%h cur_seq=%h, required %h and 000", store_seqs, cur_seq, m_pack());
    end
  endtask

  task automatic test_enter_empty();
    int s0;
    do_reset();
    press(P_ENTER, 2);
    checks++;
    if (trans_req !== 1'b0) begin
      errors++;
      $display("FAIL enter_empty: trans_req=%b, required 0", trans_req);
    end
    s0 = sent_cnt;
    pulse_ack();
    checks++;
    if (sent_cnt != s0) begin
      errors++;
      $display("FAIL ack_idle: %0d sent pulses, required 0", sent_cnt - s0);
    end
  endtask

  task automatic test_reset_mid_req();
    int s0;
    do_reset();
    press(P_DASH, 2);
    press(P_END, 2);
    press(P_ENTER, 2);
    checks++;
    if (trans_req !== 1'b1) begin
      errors++;
      $display("FAIL req_before_reset: trans_req=%b, required 1", trans_req);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({trans_req, sent, store_wr, overflow, dot_buzzer, dash_buzzer, slot_cnt, store_seqs, cur_seq} !== 48'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b sent=%b slot_cnt=%0d store_seqs=%h cur_seq=%h, required all 0",
               trans_req, sent, slot_cnt, store_seqs, cur_seq);
    end
    m_slots.delete();
    m_syms.delete();
    m_req = 1'b0;
    m_ovf = 1'b0;
    s0 = sent_cnt;
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    pulse_ack();
    repeat (3) @(negedge clk);
    checks++;
    if (sent_cnt != s0 || trans_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: sent pulses=%0d req=%b, required 0 and 0", sent_cnt - s0, trans_req);
    end
  endtask

  task automatic test_random();
    logic [5:0] m;
    int r, s0;
    do_reset();
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 35) m = P_DOT;
      else if (r < 60) m = P_DASH;
      else if (r < 70) m = P_END;
      else if (r < 78) m = P_SPACE;
      else if (r < 84) m = P_ENTER;
      else if (r < 88) m = P_CLEAR;
      else m = 6'($urandom_range(1, 63));
      press(m, $urandom_range(1, 4));
      checks++;
      if (cur_seq !== m_cur() || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_seq it%0d: cur_seq=%h ovf=%b, required %h and %b", it, cur_seq, overflow, m_cur(), m_ovf);
      end
      checks++;
      if (store_seqs !== m_pack() || slot_cnt !== 2'(m_slots.size()) || trans_req !== m_req) begin
        errors++;
        $display("FAIL rand_slots it%0d: store_seqs=%h slot_cnt=%0d req=%b, required %h %0d %b",
                 it, store_seqs, slot_cnt, trans_req, m_pack(), m_slots.size(), m_req);
      end
      if (m_req && $urandom_range(0, 2) == 0) begin
        s0 = sent_cnt;
        pulse_ack();
        m_slots.delete();
        m_ovf = 1'b0;
        m_req = 1'b0;
        checks++;
        if (sent_cnt - s0 != 1 || slot_cnt !== 2'd0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL rand_sent it%0d: sent pulses=%0d slot_cnt=%0d ovf=%b, required 1, 0, 0",
                   it, sent_cnt - s0, slot_cnt, overflow);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_simultaneous();
    test_scenario();
    test_overflow();
    test_space();
    test_full_slots();
    test_enter_empty();
    test_reset_mid_req();
    test_random();
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
